data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-master, one-slave arbiter sharing the single data-memory port between the CV32 core data interface (m0) and a secondary bus master (m1, e.g. debug/DMA loader).
- Sits between the masters and data_memory using the same req/gnt/rvalid protocol.
- Round-robin request arbitration with request lock until grant.
- Owner-tracking FIFO routes each response (rvalid/rdata) back to the master that issued it.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; BE width = DATA_W/8.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m0_req_i / m1_req_i  in  1  master request
- m0_gnt_o / m1_gnt_o  out  1  master grant
- m0_rvalid_o / m1_rvalid_o  out  1  master response valid
- m0_addr_i / m1_addr_i  in  ADDR_W  master address
- m0_we_i / m1_we_i  in  1  master write enable
- m0_be_i / m1_be_i  in  DATA_W/8  master byte enables
- m0_wdata_i / m1_wdata_i  in  DATA_W  master write data
- m0_rdata_o / m1_rdata_o  out  DATA_W  response data (copy of s_rdata_i)
- s_req_o  out  1  slave request
- s_gnt_i  in  1  slave grant
- s_rvalid_i  in  1  slave response valid
- s_addr_o  out  ADDR_W  slave address
- s_we_o  out  1  slave write enable
- s_be_o  out  DATA_W/8  slave byte enables
- s_wdata_o  out  DATA_W  slave write data
- s_rdata_i  in  DATA_W  slave read data
- err_o  out  1  sticky protocol error: rvalid received with no outstanding transaction

Behaviour:
- Reset (async, rst_ni=0):
  - last_ptr=1, so m0 wins the first tie.
  - lock=0, FIFO count=0, err_o=0.
  - s_req_o=0; all m*_gnt_o=0; all m*_rvalid_o=0.
- Selection:
  - If lock is set, sel = locked master.
  - Otherwise the single requester is selected; if both request, sel = the master that is not last_ptr.
  - If neither requests, s_req_o=0.
- Request path (combinational):
  - s_req_o = selected req AND (count < MAX_OUTSTANDING).
  - s_addr/we/be/wdata are muxed from sel.
- Grant path: mX_gnt_o = s_gnt_i AND s_req_o AND (sel==X); the unselected master's gnt_o is 0.
- Lock:
  - Set on the cycle s_req_o=1 and s_gnt_i=0, so the selection is held until grant and the OBI req-stable rule holds.
  - Cleared on handshake (s_req_o AND s_gnt_i).
  - last_ptr := sel on handshake.
- Owner FIFO:
  - Push sel on handshake; pop on s_rvalid_i.
  - Simultaneous push and pop: count unchanged, entries ordered correctly.
  - count==MAX_OUTSTANDING blocks new requests even if a pop occurs in the same cycle; no combinational rvalid→req path.
- Response routing:
  - mX_rvalid_o = s_rvalid_i AND count>0 AND head==X.
  - m0_rdata_o = m1_rdata_o = s_rdata_i.
- Error: s_rvalid_i with count==0 → rvalid dropped, err_o set, cleared only by reset.
- Latency: zero added cycles on request and response paths (pure mux plus bookkeeping).
- Back-to-back: one handshake per cycle is sustained while the FIFO is not full.
- Reset mid-transaction: the FIFO is flushed; a late slave rvalid after reset raises err_o.

Decomposition:
- soc_config_pkg gains:
  - typedef logic arb_master_id_t (0=core, 1=aux);
  - constant DATA_ARB_MAX_OUTSTANDING = 2.
- Sub-module arb_owner_fifo:
  - Parameter DEPTH; ports clk_i, rst_ni, push_i, id_i, pop_i, head_o, count_o, full_o, empty_o.
  - Circular buffer with wrap-around pointers.
- Top module holds the selection logic, lock, last_ptr, muxes and error flag.

Test Plan:
- Single master: m0 reads 0x0000_0010, slave grants the same cycle, rvalid next cycle with 0xDEADBEEF → m0_gnt_o=1 at cycle 0, m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF at cycle 1, m1 signals stay 0.
- Tie after reset: m0 and m1 both request continuously with s_gnt_i=1 → grants alternate m0,m1,m0,m1; rvalids route in the same order.
- Lock: m1 alone requests, s_gnt_i=0 for 3 cycles, m0 starts requesting at cycle 1 → s_addr_o stays m1's address until the grant in cycle 3; m0 is granted in cycle 4.
- Backpressure: MAX_OUTSTANDING=2, two handshakes with no rvalid → s_req_o=0 and gnt_o=0 despite a pending req; one rvalid → requests resume the next cycle.
- Mixed ordering: m0 write to 0x20, then m1 read of 0x24 with rvalids on consecutive cycles → m0_rvalid_o then m1_rvalid_o, never both.
- Spurious rvalid after reset with count==0 → no m*_rvalid_o and err_o=1 until rst_ni is asserted low.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and sizing constants for the data-memory arbiter.
package data_mem_arbiter_pkg;

  // Master identifier: 0 = core data port, 1 = auxiliary (debug/DMA) master.
  typedef logic arb_master_id_t;

  localparam arb_master_id_t ARB_CORE = 1'b0;
  localparam arb_master_id_t ARB_AUX  = 1'b1;

  localparam int DATA_ARB_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/data_mem_arbiter_owner_fifo.sv
// Owner-tracking FIFO: remembers which master issued each accepted transaction
// so responses can be returned in order.
module arb_owner_fifo
  import data_mem_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             id_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  arb_master_id_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is only meaningful below count_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= id_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter in front of the single data-memory port;
// responses are steered back by an in-order owner FIFO.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = DATA_ARB_MAX_OUTSTANDING
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_req_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_req_o,
  input  logic                s_gnt_i,
  input  logic                s_rvalid_i,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_master_id_t sel;
  logic           sel_req, handshake, pop;
  logic           fifo_head, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;

  arb_master_id_t last_ptr_q, last_ptr_d;
  arb_master_id_t lock_id_q, lock_id_d;
  logic           lock_q, lock_d;
  logic           err_q, err_d;

  // A locked selection is held until granted; otherwise a tie goes to the
  // master that did not win the previous handshake.
  always_comb begin
    sel = ARB_CORE;
    if (lock_q)                      sel = lock_id_q;
    else if (m0_req_i && m1_req_i)   sel = ~last_ptr_q;
    else if (m1_req_i)               sel = ARB_AUX;
  end

  assign sel_req   = (sel == ARB_AUX) ? m1_req_i : m0_req_i;
  assign s_req_o   = sel_req & ~fifo_full;
  assign handshake = s_req_o & s_gnt_i;

  assign s_addr_o  = (sel == ARB_AUX) ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = (sel == ARB_AUX) ? m1_we_i    : m0_we_i;
  assign s_be_o    = (sel == ARB_AUX) ? m1_be_i    : m0_be_i;
  assign s_wdata_o = (sel == ARB_AUX) ? m1_wdata_i : m0_wdata_i;

  assign m0_gnt_o  = handshake & (sel == ARB_CORE);
  assign m1_gnt_o  = handshake & (sel == ARB_AUX);

  assign pop         = s_rvalid_i & ~fifo_empty;
  assign m0_rvalid_o = s_rvalid_i & (fifo_cnt != '0) & (fifo_head == ARB_CORE);
  assign m1_rvalid_o = s_rvalid_i & (fifo_cnt != '0) & (fifo_head == ARB_AUX);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  always_comb begin
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    last_ptr_d = last_ptr_q;
    if (handshake) begin
      lock_d     = 1'b0;
      last_ptr_d = sel;
    end else if (s_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
    err_d = err_q | (s_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_ptr_q <= ARB_AUX;
      lock_id_q  <= ARB_CORE;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      last_ptr_q <= last_ptr_d;
      lock_id_q  <= lock_id_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

  arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .id_i    (sel),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic against
// a transaction-level model of arbitration and in-order response ownership.
module tb_data_mem_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_be = '0, m1_be = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, err;
  logic        s_gnt = 1'b0, s_rvalid = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic [31:0] s_rdata = '0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
    .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
    .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .err_o(err)
  );

  int total = 0;
  int bad   = 0;

  // Model: queue of owners of accepted transactions, previous winner,
  // a pending (requested but not granted) master, and the sticky error.
  int owners[$];
  bit last_win = 1'b1;
  bit pending  = 1'b0;
  bit pend_id  = 1'b0;
  bit m_err    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input bit idx, input logic [31:0] a, input bit we,
                       input logic [3:0] be, input logic [31:0] wd);
    if (idx) begin m1_addr = a; m1_we = we; m1_be = be; m1_wdata = wd; end
    else     begin m0_addr = a; m0_we = we; m0_be = be; m0_wdata = wd; end
  endtask

  function automatic void model_reset();
    owners.delete();
    last_win = 1'b1;
    pending  = 1'b0;
    m_err    = 1'b0;
  endfunction

  task automatic cyc(input bit r0, input bit r1, input bit g, input bit rv,
                     input logic [31:0] rd);
    int cnt;
    bit want, wreq, esreq;
    m0_req = r0; m1_req = r1; s_gnt = g; s_rvalid = rv; s_rdata = rd;
    #2;
    cnt = owners.size();
    if (pending)       want = pend_id;
    else if (r0 && r1) want = !last_win;
    else               want = r1;
    wreq  = want ? r1 : r0;
    esreq = wreq && (cnt < MAXO);
    chk("s_req", s_req, esreq);
    chk("m0_gnt", m0_gnt, esreq && g && !want);
    chk("m1_gnt", m1_gnt, esreq && g && want);
    chk("m0_rvalid", m0_rvalid, rv && cnt > 0 && owners[0] == 0);
    chk("m1_rvalid", m1_rvalid, rv && cnt > 0 && owners[0] == 1);
    chk("m0_rdata", m0_rdata, rd);
    chk("m1_rdata", m1_rdata, rd);
    chk("err", err, m_err);
    if (esreq) begin
      chk("s_addr",  s_addr,  want ? m1_addr  : m0_addr);
      chk("s_we",    s_we,    want ? m1_we    : m0_we);
      chk("s_be",    s_be,    want ? m1_be    : m0_be);
      chk("s_wdata", s_wdata, want ? m1_wdata : m0_wdata);
    end
    @(posedge clk);
    if (rv) begin
      if (cnt > 0) void'(owners.pop_front());
      else         m_err = 1'b1;
    end
    if (esreq && g) begin
      owners.push_back(int'(want));
      last_win = want;
      pending  = 1'b0;
    end else if (esreq) begin
      pending = 1'b1;
      pend_id = want;
    end
    #1;
  endtask

  task automatic do_reset();
    m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_s_req", s_req, 1'b0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    chk("rst_err", err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, owners.size() > 0, 32'h1000 + i);
  endtask

  initial begin
    bit r0, r1, g, rv;
    do_reset();

    // Single master read with same-cycle grant, response next cycle
    set_m(0, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
    cyc(1, 0, 1, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'hDEAD_BEEF);

    // Continuous tie after reset: alternate m0, m1, ...
    do_reset();
    set_m(0, 32'h0000_0040, 1'b0, 4'hF, 32'h0);
    set_m(1, 32'h0000_0080, 1'b1, 4'h3, 32'hCAFE_0001);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, i > 0, 32'hA000_0000 + i);
    drain();

    // Lock: m1 held for three ungranted cycles while m0 joins
    set_m(1, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    set_m(0, 32'h0000_0200, 1'b1, 4'h1, 32'h1234_5678);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    drain();

    // Backpressure: two outstanding blocks further requests, even on a pop
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 32'h5555_AAAA);
    cyc(1, 1, 1, 0, 0);
    drain();

    // Mixed: m0 write then m1 read, responses on consecutive cycles
    set_m(0, 32'h0000_0020, 1'b1, 4'hF, 32'h0BAD_F00D);
    set_m(1, 32'h0000_0024, 1'b0, 4'hF, 32'h0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 32'h1111_1111);
    cyc(0, 0, 0, 1, 32'h2222_2222);

    // Random traffic with OBI-compliant held requests
    for (int i = 0; i < 400; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (pending) begin
        if (pend_id) r1 = 1'b1;
        else         r0 = 1'b1;
      end
      if (!(pending && !pend_id)) set_m(0, $urandom, 1'($urandom), 4'($urandom), $urandom);
      if (!(pending &&  pend_id)) set_m(1, $urandom, 1'($urandom), 4'($urandom), $urandom);
      g  = ($urandom_range(0, 3) != 0);
      rv = (owners.size() > 0) && 1'($urandom_range(0, 1));
      cyc(r0, r1, g, rv, $urandom);
    end

    // Reset with transactions in flight, then a late response
    cyc(1, 0, 1, 0, 0);
    do_reset();
    cyc(0, 0, 0, 1, 32'hFEED_0000);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 32'h7777_0000);
    do_reset();
    cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
